// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA raster from the scaled frame RAM, image centred on a black border.
// Define FB_TESTPAT_EN for a test_en input that overlays a coordinate test pattern; IMG_SHIFT shrinks the image modes for reduced rasters.
module vga_frame_reader #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ADDR_W    = 19,
  parameter int IMG_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        seletor,
`ifdef FB_TESTPAT_EN
  input  logic              test_en,
`endif
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [7:0]        ram_q,
  output logic [7:0]        pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start
);
  localparam int H_T = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_T);
  localparam int VW = $clog2(V_T);
  localparam logic [HW-1:0] H_LAST = HW'(H_T - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_T - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int W_REP = 320 >> IMG_SHIFT;
  localparam int H_REP = 240 >> IMG_SHIFT;
  localparam int W_DEC = 80 >> IMG_SHIFT;
  localparam int H_DEC = 60 >> IMG_SHIFT;
  localparam int W_ORG = 160 >> IMG_SHIFT;
  localparam int H_ORG = 120 >> IMG_SHIFT;
  localparam logic [HW-1:0] X0_REP = HW'((H_ACTIVE - W_REP) / 2);
  localparam logic [HW-1:0] X1_REP = HW'((H_ACTIVE - W_REP) / 2 + W_REP);
  localparam logic [HW-1:0] X0_DEC = HW'((H_ACTIVE - W_DEC) / 2);
  localparam logic [HW-1:0] X1_DEC = HW'((H_ACTIVE - W_DEC) / 2 + W_DEC);
  localparam logic [HW-1:0] X0_ORG = HW'((H_ACTIVE - W_ORG) / 2);
  localparam logic [HW-1:0] X1_ORG = HW'((H_ACTIVE - W_ORG) / 2 + W_ORG);
  localparam logic [VW-1:0] Y0_REP = VW'((V_ACTIVE - H_REP) / 2);
  localparam logic [VW-1:0] Y1_REP = VW'((V_ACTIVE - H_REP) / 2 + H_REP);
  localparam logic [VW-1:0] Y0_DEC = VW'((V_ACTIVE - H_DEC) / 2);
  localparam logic [VW-1:0] Y1_DEC = VW'((V_ACTIVE - H_DEC) / 2 + H_DEC);
  localparam logic [VW-1:0] Y0_ORG = VW'((V_ACTIVE - H_ORG) / 2);
  localparam logic [VW-1:0] Y1_ORG = VW'((V_ACTIVE - H_ORG) / 2 + H_ORG);

  logic [HW-1:0]     h_cnt, x0, x1;
  logic [VW-1:0]     v_cnt, y0, y1;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr;
  logic              at_origin, in_img, in_img1, hs1, vs1, blank1, fs1;
  logic [7:0]        pat1;
  logic              ten1;

  always_comb begin
    at_origin = h_cnt == '0 && v_cnt == '0;
    x0 = mode == 2'b00 ? X0_REP : mode == 2'b01 ? X0_DEC : X0_ORG;
    x1 = mode == 2'b00 ? X1_REP : mode == 2'b01 ? X1_DEC : X1_ORG;
    y0 = mode == 2'b00 ? Y0_REP : mode == 2'b01 ? Y0_DEC : Y0_ORG;
    y1 = mode == 2'b00 ? Y1_REP : mode == 2'b01 ? Y1_DEC : Y1_ORG;
    in_img = h_cnt >= x0 && h_cnt < x1 && v_cnt >= y0 && v_cnt < y1;
  end

  // Raster position, per-frame mode latch and the linear read address
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      mode  <= 2'b00;
      addr  <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + HW'(1);
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + VW'(1);
      if (at_origin) mode <= seletor;
      addr <= at_origin ? '0 : addr + ADDR_W'(in_img);
    end

  // Stage 1 issues the RAM read alongside the raster flags; stage 2 meets the RAM data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ram_rdaddr  <= '0;
      in_img1     <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      blank1      <= 1'b0;
      fs1         <= 1'b0;
      pat1        <= '0;
      ten1        <= 1'b0;
      pixel       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (in_img) ram_rdaddr <= addr;
      in_img1     <= in_img;
      hs1         <= !(h_cnt >= HS_BEG && h_cnt <= HS_END);
      vs1         <= !(v_cnt >= VS_BEG && v_cnt <= VS_END);
      blank1      <= h_cnt < H_VIS && v_cnt < V_VIS;
      fs1         <= at_origin;
      pat1        <= {h_cnt[5:3], v_cnt[5:3], 2'b11};
`ifdef FB_TESTPAT_EN
      ten1        <= test_en;
`else
      ten1        <= 1'b0;
`endif
      pixel       <= !in_img1 ? 8'h00 : ten1 ? pat1 : ram_q;
      hsync       <= hs1;
      vsync       <= vs1;
      blank_n     <= blank1;
      frame_start <= fs1;
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: scoreboard bench for vga_frame_reader on a reduced raster (80x60 active, 100x66 total, images scaled by 1/8).
// Modes at this scale: 00 -> 40x30 at (20,15), 01 -> 10x7 at (35,26), 1x -> 20x15 at (30,22).
module tb_vga_frame_reader;
  localparam int HT = 100;
  localparam int VT = 66;

  typedef struct {
    int          h;
    int          v;
    logic        inimg;
    logic [18:0] rd;
    logic [7:0]  pix;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  seletor = 2'b00;
  logic        test_en = 1'b0;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q, pixel;
  logic        hsync, vsync, blank_n, frame_start;
  int          checks = 0;
  int          failures = 0;
  exp_t        q[$];
  int          mh, mv;
  logic [1:0]  mmode;
  logic [18:0] mlast;

  always #5 clk = ~clk;
  assign ram_q = ram_rdaddr[7:0];

  vga_frame_reader #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(8),
    .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .ADDR_W(19), .IMG_SHIFT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seletor(seletor),
`ifdef FB_TESTPAT_EN
    .test_en(test_en),
`endif
    .ram_rdaddr(ram_rdaddr),
    .ram_q(ram_q),
    .pixel(pixel),
    .hsync(hsync),
    .vsync(vsync),
    .blank_n(blank_n),
    .frame_start(frame_start)
  );

  function automatic exp_t model(int h, int v, logic [1:0] m, logic ten, logic [18:0] last);
    exp_t e;
    int w, ih, x0, y0;
    logic [31:0] hb, vb;
    w  = (m == 2'b00) ? 40 : (m == 2'b01) ? 10 : 20;
    ih = (m == 2'b00) ? 30 : (m == 2'b01) ? 7 : 15;
    x0 = (80 - w) / 2;
    y0 = (60 - ih) / 2;
    hb = h;
    vb = v;
    e.h = h;
    e.v = v;
    e.inimg = h >= x0 && h < x0 + w && v >= y0 && v < y0 + ih;
    e.rd = e.inimg ? 19'((v - y0) * w + h - x0) : last;
    e.pix = !e.inimg ? 8'h00 : ten ? {hb[5:3], vb[5:3], 2'b11} : e.rd[7:0];
    e.hs = !(h >= 84 && h <= 91);
    e.vs = !(v >= 62 && v <= 63);
    e.bl = h < 80 && v < 60;
    e.fs = h == 0 && v == 0;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.h = -1; e.v = -1; e.inimg = 1'b0; e.rd = '0; e.pix = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  // Expectation for each raster position is pushed as the DUT consumes it; q[0] matches stage 2, q[1] stage 1
  always @(posedge clk or negedge reset)
    if (!reset) begin
      q.delete();
      q.push_back(rst_exp());
      q.push_back(rst_exp());
      mh <= 0;
      mv <= 0;
      mmode <= 2'b00;
      mlast <= '0;
    end else begin
      exp_t e;
      logic [1:0] m;
      m = (mh == 0 && mv == 0) ? seletor : mmode;
      e = model(mh, mv, m, test_en, mlast);
      q.push_back(e);
      void'(q.pop_front());
      mmode <= m;
      mlast <= e.rd;
      mh <= (mh == HT - 1) ? 0 : mh + 1;
      if (mh == HT - 1) mv <= (mv == VT - 1) ? 0 : mv + 1;
    end

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_rdaddr, pixel, hsync, vsync, blank_n, frame_start} !== {19'd0, 8'd0, 4'b1100}) begin
      failures++;
      $display("FAIL reset_hold: got rd=%0d pix=%0h hs=%b vs=%b bl=%b fs=%b, required rd=0 pix=0 hs=1 vs=1 bl=0 fs=0",
               ram_rdaddr, pixel, hsync, vsync, blank_n, frame_start);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      failures++;
      $display("FAIL fs_early: got frame_start=%b 1 clk after release, required 0", frame_start);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL fs_first: got frame_start=%b 2 clk after release, required 1", frame_start);
    end
  endtask

  task automatic test_sync;
    int hs_lo = 0, vs_lo = 0, bl_hi = 0, fs_n = 0;
    repeat (HT * VT) begin
      @(negedge clk);
      checks++;
      if ({hsync, vsync, blank_n, frame_start} !== {q[0].hs, q[0].vs, q[0].bl, q[0].fs}) begin
        failures++;
        $display("FAIL sync h=%0d v=%0d: got hs/vs/bl/fs=%b%b%b%b, required %b%b%b%b",
                 q[0].h, q[0].v, hsync, vsync, blank_n, frame_start, q[0].hs, q[0].vs, q[0].bl, q[0].fs);
      end
      hs_lo += int'(hsync === 1'b0);
      vs_lo += int'(vsync === 1'b0);
      bl_hi += int'(blank_n === 1'b1);
      fs_n  += int'(frame_start === 1'b1);
    end
    checks++;
    if (hs_lo != 8 * VT) begin failures++; $display("FAIL hsync_count: got %0d low clk per frame, required %0d", hs_lo, 8 * VT); end
    checks++;
    if (vs_lo != 2 * HT) begin failures++; $display("FAIL vsync_count: got %0d low clk per frame, required %0d", vs_lo, 2 * HT); end
    checks++;
    if (bl_hi != 80 * 60) begin failures++; $display("FAIL blank_count: got %0d active clk per frame, required %0d", bl_hi, 80 * 60); end
    checks++;
    if (fs_n != 1) begin failures++; $display("FAIL fs_count: got %0d frame_start pulses per frame, required 1", fs_n); end
  endtask

  task automatic test_image;
    do begin
      @(negedge clk);
      checks++;
      if (pixel !== q[0].pix || ram_rdaddr !== q[1].rd) begin
        failures++;
        $display("FAIL image h=%0d v=%0d: got pix=%0h rd=%0d, required pix=%0h rd=%0d",
                 q[0].h, q[0].v, pixel, ram_rdaddr, q[0].pix, q[1].rd);
      end
      if (q[0].h == 20 && q[0].v == 15) begin
        checks++;
        if (pixel !== 8'h00) begin failures++; $display("FAIL first_pixel: got %0h, required 00", pixel); end
      end
      if (q[1].h == 20 && q[1].v == 15) begin
        checks++;
        if (ram_rdaddr !== 19'd0) begin failures++; $display("FAIL first_addr: got %0d, required 0", ram_rdaddr); end
      end
      if (q[1].h == 59 && q[1].v == 15) begin
        checks++;
        if (ram_rdaddr !== 19'd39) begin failures++; $display("FAIL line_end_addr: got %0d, required 39", ram_rdaddr); end
      end
      if (q[0].h == 21 && q[0].v == 16) begin
        checks++;
        if (pixel !== 8'd41) begin failures++; $display("FAIL interior_pixel: got %0h, required %0h", pixel, 8'd41); end
      end
      if ((q[0].h == 19 || q[0].h == 60) && q[0].v == 20) begin
        checks++;
        if (pixel !== 8'h00) begin failures++; $display("FAIL border h=%0d: got %0h, required 00", q[0].h, pixel); end
      end
    end while (!(q[0].v == 38 && q[0].h == 0));
    seletor = 2'b01;
  endtask

  task automatic test_mode_switch;
    int frame = 0, max_a = 0, max_b = 0;
    int hmin = 999, hmax = -1, vmin = 999, vmax = -1;
    do begin
      @(negedge clk);
      if (q[0].fs) frame++;
      checks++;
      if (pixel !== q[0].pix || ram_rdaddr !== q[1].rd) begin
        failures++;
        $display("FAIL switch h=%0d v=%0d: got pix=%0h rd=%0d, required pix=%0h rd=%0d",
                 q[0].h, q[0].v, pixel, ram_rdaddr, q[0].pix, q[1].rd);
      end
      if (frame == 0 && int'(ram_rdaddr) > max_a) max_a = int'(ram_rdaddr);
      if (frame == 1 && q[1].inimg && int'(ram_rdaddr) > max_b) max_b = int'(ram_rdaddr);
      if (frame == 1 && pixel !== 8'h00) begin
        if (q[0].h < hmin) hmin = q[0].h;
        if (q[0].h > hmax) hmax = q[0].h;
        if (q[0].v < vmin) vmin = q[0].v;
        if (q[0].v > vmax) vmax = q[0].v;
      end
    end while (frame < 2);
    checks++;
    if (max_a != 1199) begin failures++; $display("FAIL old_mode_last: got %0d, required 1199", max_a); end
    checks++;
    if (max_b != 69) begin failures++; $display("FAIL new_mode_last: got %0d, required 69", max_b); end
    checks++;
    if (hmin != 35 || hmax != 44 || vmin != 26 || vmax != 32) begin
      failures++;
      $display("FAIL new_window: got h %0d..%0d v %0d..%0d, required h 35..44 v 26..32", hmin, hmax, vmin, vmax);
    end
  endtask

  task automatic test_reset_mid;
    do @(negedge clk); while (!(mh == 50 && mv == 25));
    checks++;
    if (blank_n !== q[0].bl) begin failures++; $display("FAIL pre_reset_blank: got %b, required %b", blank_n, q[0].bl); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ram_rdaddr, pixel, hsync, vsync, blank_n, frame_start} !== {19'd0, 8'd0, 4'b1100}) begin
      failures++;
      $display("FAIL reset_async: got rd=%0d pix=%0h hs=%b vs=%b bl=%b fs=%b, required rd=0 pix=0 hs=1 vs=1 bl=0 fs=0",
               ram_rdaddr, pixel, hsync, vsync, blank_n, frame_start);
    end
    seletor = 2'b10;
`ifdef FB_TESTPAT_EN
    test_en = 1'b1;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || ram_rdaddr !== 19'd0) begin
      failures++;
      $display("FAIL restart: got fs=%b rd=%0d, required fs=1 rd=0", frame_start, ram_rdaddr);
    end
  endtask

  task automatic test_pattern;
    int max_rd = 0;
    repeat (HT * VT - 1) begin
      @(negedge clk);
      checks++;
      if (pixel !== q[0].pix || ram_rdaddr !== q[1].rd || {hsync, vsync, blank_n} !== {q[0].hs, q[0].vs, q[0].bl}) begin
        failures++;
        $display("FAIL orig h=%0d v=%0d: got pix=%0h rd=%0d hs/vs/bl=%b%b%b, required pix=%0h rd=%0d %b%b%b",
                 q[0].h, q[0].v, pixel, ram_rdaddr, hsync, vsync, blank_n, q[0].pix, q[1].rd, q[0].hs, q[0].vs, q[0].bl);
      end
      if (int'(ram_rdaddr) > max_rd) max_rd = int'(ram_rdaddr);
`ifdef FB_TESTPAT_EN
      if (q[0].h == 30 && q[0].v == 22) begin
        checks++;
        if (pixel !== 8'h6B) begin failures++; $display("FAIL pattern_pixel: got %0h, required 6b", pixel); end
      end
`else
      if (q[0].h == 31 && q[0].v == 22) begin
        checks++;
        if (pixel !== 8'h01) begin failures++; $display("FAIL orig_pixel: got %0h, required 01", pixel); end
      end
`endif
      if (q[0].h == 29 && q[0].v == 22) begin
        checks++;
        if (pixel !== 8'h00) begin failures++; $display("FAIL orig_border: got %0h, required 00", pixel); end
      end
    end
    checks++;
    if (max_rd != 299) begin failures++; $display("FAIL orig_last: got %0d, required 299", max_rd); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_image();
    test_mode_switch();
    test_reset_mid();
    test_pattern();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench still running after 2 ms, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Reads the 8-bit frame RAM filled by the scaling writer and drives a 640x480@60 VGA raster from it. The stored image is centred in the active area with a black border. The image size follows the writer's scaling mode: 00 replication 320x240, 01 decimation 80x60, 10/11 original 160x120. The block sits between the RAM read port and the DAC/VGA pins and runs on the 25 MHz pixel clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- ADDR_W, 19, RAM address width

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low
- seletor  in  2  scaling mode, same encoding as the writer
- ram_rdaddr  out  ADDR_W  RAM read address, registered
- ram_q  in  8  RAM read data, valid one clk after ram_rdaddr
- pixel  out  8  colour to DAC, 0 outside the image
- hsync  out  1  active-low
- vsync  out  1  active-low
- blank_n  out  1  high during the 640x480 active area
- frame_start  out  1  one-cycle pulse at the first output pixel (h=0, v=0)

## Operation
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps. It runs 0..524 and wraps to 0.
- Mode latch:
  - seletor is sampled into img_w/img_h only when h_cnt=0 and v_cnt=0.
  - A change mid-frame takes effect at the next frame.
  - Reset value is the 320x240 mode.
- Window:
  - x0=(640-img_w)/2, y0=(480-img_h)/2.
  - Per mode: 320x240 → (160,120); 160x120 → (240,180); 80x60 → (280,210).
  - in_img is true when x0 ≤ h_cnt < x0+img_w and y0 ≤ v_cnt < y0+img_h.
- Address:
  - Address is an incremental counter, with no multiplier.
  - It clears to 0 at h_cnt=0,v_cnt=0 and increments by 1 after each in_img cycle.
  - ram_rdaddr is registered from this counter on in_img cycles and holds its value otherwise.
  - Last address per frame is img_w*img_h-1: 76799, 19199 or 4799.
- Sync windows:
  - hsync is low when 656 ≤ h_cnt ≤ 751.
  - vsync is low when 490 ≤ v_cnt ≤ 491.
  - blank_n is h_cnt<640 && v_cnt<480.
- Output: pixel = in_img (delayed) ? ram_q : 0. Porch and sync regions always output 0.
- Reset mid-frame: all counters and outputs return to their reset values immediately (asynchronous). The raster restarts at h=0,v=0.

## Timing
- Pipeline:
  - Stage 1 registers ram_rdaddr, in_img, the sync terms and blank.
  - Stage 2 registers pixel, hsync, vsync, blank_n and frame_start.
  - Every output therefore lags its (h_cnt,v_cnt) position by exactly 2 clk.
  - All outputs are aligned with one another.
- Reset values: ram_rdaddr=0, pixel=0, hsync=1, vsync=1, blank_n=0, frame_start=0, h_cnt=v_cnt=0.
- Line = 800 clk. Frame = 420000 clk.
- frame_start asserts for 1 clk every 420000 clk. The first pulse comes 2 clk after reset deassertion.

## Configuration
- FB_TESTPAT_EN defined:
  - Adds input test_en (1 bit).
  - While test_en=1, in-image pixels output {h_cnt[5:3], v_cnt[5:3], 2'b11} instead of ram_q.
  - Borders stay 0. Address generation is unchanged.
  - test_en is sampled with the pipeline, not latched per frame.
- FB_TESTPAT_EN undefined: there is no test_en port and pixel always comes from ram_q.

## Test plan
- Reset held, then released: all outputs at their reset values during reset. The first frame_start comes 2 clk after release.
- Free run two frames:
  - hsync low for 96 clk every 800 clk.
  - vsync low for 1600 clk every 420000 clk.
  - blank_n high for 640 clk per line on 480 lines.
- seletor=00, RAM model returns addr[7:0]:
  - The first image pixel at h=160,v=120 shows ram_rdaddr=0 and pixel=0x00.
  - Line end at h=479 gives address 319.
  - The frame's last address is 76799.
  - pixel=0 at h=159 and h=480.
- seletor switched 00→01 at v=300: the rest of the current frame stays 320x240. The next frame's window is h 280..359, v 210..269, with last address 4799.
- Reset pulsed at v=200,h=400: outputs return to reset values asynchronously. The raster and address restart from 0 after release.
- FB_TESTPAT_EN with test_en=1, seletor=10: at h=240,v=180 pixel equals {3'd6, 3'd6, 2'b11}=0xDB; the border stays 0.
